// File: rtl/alu_op_sequencer.sv
// Command sequencer and checker for the registered 4-op ALU: issues operands,
// waits out the ALU pipeline, captures and checks the result against a reference.
module alu_op_sequencer #(
  parameter int WIDTH   = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_din0,
  output logic [WIDTH-1:0] alu_din1,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             err_sticky,
  output logic [WIDTH-1:0] acc
);

  // state | meaning
  // IDLE  | ready for a command
  // WAIT  | operands issued, counting down the ALU latency
  // OUT   | result presented, waiting for res_ready
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_t           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] model;
  logic [WIDTH-1:0] op_a;
  logic             mismatch;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a + (~b) + WIDTH'(1);
      2'b10:   r = a & b;
      default: r = {1'b0, a[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign op_a      = cmd_chain ? acc : cmd_a;
  assign mismatch  = (alu_dout != model);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      model      <= '0;
      alu_din0   <= '0;
      alu_din1   <= '0;
      alu_sel    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
      err_sticky <= 1'b0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_din0 <= op_a;
            alu_din1 <= cmd_b;
            alu_sel  <= cmd_op;
            model    <= alu_ref(cmd_op, op_a, cmd_b);
            cnt      <= LAT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 3'd1;
          end else begin
            res_data   <= alu_dout;
            acc        <= alu_dout;
            res_err    <= mismatch;
            err_sticky <= err_sticky | mismatch;
            res_valid  <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural registered ALU with an injectable
// output fault, table-driven command vectors and a few multi-cycle sequences.
module tb_alu_op_sequencer;
  localparam int WIDTH = 3;
  localparam int LAT   = 1;

  logic             clk = 0;
  logic             rst;
  logic             cmd_valid, cmd_chain, res_ready;
  logic             cmd_ready, res_valid, res_err, err_sticky;
  logic [1:0]       cmd_op, alu_sel;
  logic [WIDTH-1:0] cmd_a, cmd_b, alu_din0, alu_din1, alu_dout, res_data, acc;
  logic [WIDTH-1:0] corrupt;
  logic [WIDTH-1:0] pipe [LAT];

  int n_pass = 0;
  int n_total = 0;

  alu_op_sequencer #(.WIDTH(WIDTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_din0(alu_din0), .alu_din1(alu_din1), .alu_sel(alu_sel),
    .alu_dout(alu_dout), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .err_sticky(err_sticky), .acc(acc)
  );

  always #5 clk = ~clk;

  // behavioural ALU: LAT register stages, output optionally corrupted
  always @(posedge clk) begin
    case (alu_sel)
      2'b00:   pipe[0] <= alu_din0 + alu_din1;
      2'b01:   pipe[0] <= alu_din0 - alu_din1;
      2'b10:   pipe[0] <= alu_din0 & alu_din1;
      default: pipe[0] <= alu_din0 >> 1;
    endcase
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_dout = pipe[LAT-1] ^ corrupt;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             chain;
    logic [WIDTH-1:0] exp_din0, exp_res;
  } vec_t;

  // issue one command and wait for its result; leaves the bench #1 after the capture edge
  task automatic issue(input vec_t v, input logic rdy);
    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_chain = v.chain;
    res_ready = rdy;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_a = '1; cmd_b = '1; cmd_chain = 0;
    check("alu_sel", alu_sel, v.op);
    check("alu_din0", alu_din0, v.exp_din0);
    check("alu_din1", alu_din1, v.b);
    begin
      int cycles = 0;
      while (!res_valid && cycles < 20) begin
        @(posedge clk); #1; cycles++;
      end
      check("result_latency", cycles, LAT + 1);
    end
  endtask

  task automatic finish_ok();
    res_ready = 1;
    @(posedge clk); #1;
    check("res_valid_drop", res_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
  endtask

  vec_t vecs [10];
  vec_t v;

  initial begin
    //          op     a     b     chain din0  res
    vecs[0] = '{2'b00, 3'd3, 3'd2, 1'b0, 3'd3, 3'd5};
    vecs[1] = '{2'b01, 3'd3, 3'd5, 1'b0, 3'd3, 3'd6};
    vecs[2] = '{2'b00, 3'd0, 3'd3, 1'b1, 3'd6, 3'd1};
    vecs[3] = '{2'b10, 3'd6, 3'd3, 1'b0, 3'd6, 3'd2};
    vecs[4] = '{2'b11, 3'd6, 3'd5, 1'b0, 3'd6, 3'd3};
    vecs[5] = '{2'b00, 3'd7, 3'd7, 1'b0, 3'd7, 3'd6};
    vecs[6] = '{2'b01, 3'd0, 3'd1, 1'b0, 3'd0, 3'd7};
    vecs[7] = '{2'b11, 3'd1, 3'd0, 1'b1, 3'd7, 3'd3};
    vecs[8] = '{2'b01, 3'd0, 3'd5, 1'b1, 3'd3, 3'd6};
    vecs[9] = '{2'b10, 3'd5, 3'd7, 1'b0, 3'd5, 3'd5};

    rst = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_chain = 0;
    res_ready = 0; corrupt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_acc", acc, 0);
    check("rst_alu_din0", alu_din0, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_err_sticky", err_sticky, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_res_valid", res_valid, 0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i], 1'b1);
      check("res_data", res_data, vecs[i].exp_res);
      check("res_err", res_err, 0);
      check("acc", acc, vecs[i].exp_res);
      finish_ok();
    end
    check("no_err_sticky", err_sticky, 0);

    // backpressure: result and busy status held while res_ready is low
    v = '{2'b00, 3'd2, 3'd3, 1'b0, 3'd2, 3'd5};
    issue(v, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 5);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    finish_ok();

    // corrupted ALU output: 1+1 reads back as 3
    corrupt = 3'b001;
    v = '{2'b00, 3'd1, 3'd1, 1'b0, 3'd1, 3'd2};
    issue(v, 1'b1);
    check("bad_res_data", res_data, 3);
    check("bad_res_err", res_err, 1);
    check("bad_err_sticky", err_sticky, 1);
    check("bad_acc", acc, 3);
    finish_ok();
    corrupt = 0;
    // chaining uses the captured (wrong) value: 3 & 6 = 2
    v = '{2'b10, 3'd0, 3'd6, 1'b1, 3'd3, 3'd2};
    issue(v, 1'b1);
    check("good_res_data", res_data, 2);
    check("good_res_err", res_err, 0);
    check("sticky_holds", err_sticky, 1);
    finish_ok();

    // reset one cycle after accept abandons the command
    v = '{2'b00, 3'd4, 3'd1, 1'b0, 3'd4, 3'd5};
    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; res_ready = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    check("mid_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("mrst_res_valid", res_valid, 0);
    check("mrst_acc", acc, 0);
    check("mrst_sticky", err_sticky, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    check("mrst_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mrst_no_result", res_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule
